// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared types and constants for the integer pipeline.
//   - alu_ctrl_t   : ALU operation / branch-compare encoding (4 bits)
//   - fwd_sel_t    : operand forwarding source (none / writeback / memory)
//   - result_src_t : writeback result select
//   - DATA_WIDTH, REG_ADDR_WIDTH, CONTROL_WIDTH default widths
package pipeline_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CONTROL_WIDTH  = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
//   Forwarding selector plus 3:1 operand mux for one execute-stage source operand.
//   Priority: MEM-stage result, then WB-stage result, then the register-file value
//   captured at decode. Register x0 is never forwarded.
// Ports
//   rs_e         in  source register index held in ID/EX
//   rf_data_e    in  register-file read data held in ID/EX
//   alu_result_m in  MEM-stage ALU result;  rd_m / reg_write_m in  MEM destination
//   result_w     in  WB-stage result;       rd_w / reg_write_w in  WB destination
//   fwd_data     out selected operand
//   fwd_sel      out which source was chosen
// Parameter FWD_EN = 0 disables forwarding: output is always rf_data_e / FWD_NONE.
module fwd_mux
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FWD_EN         = 1'b1
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e,
  input  logic [DATA_WIDTH-1:0]     rf_data_e,
  input  logic [DATA_WIDTH-1:0]     alu_result_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [DATA_WIDTH-1:0]     result_w,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output fwd_sel_t                  fwd_sel
);

  logic match_m;
  logic match_w;

  always_comb begin
    match_m = FWD_EN && reg_write_m && (rd_m != '0) && (rd_m == rs_e);
    match_w = FWD_EN && reg_write_w && (rd_w != '0) && (rd_w == rs_e);

    // MEM holds the younger write, so it wins when both stages match
    if (match_m)      fwd_sel = FWD_M;
    else if (match_w) fwd_sel = FWD_W;
    else              fwd_sel = FWD_NONE;

    case (fwd_sel)
      FWD_M:   fwd_data = alu_result_m;
      FWD_W:   fwd_data = result_w;
      default: fwd_data = rf_data_e;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register plus execute operand selection feeding the ALU.
//   Captures decode outputs each cycle, forwards MEM/WB results on RAW hazards and
//   drives src_a_e / src_b_e / alu_ctrl_e. Update priority: reset > flush > stall > load.
//   Reset and flush both load the all-zero bubble (ADD x0,x0, no side effects, valid_e=0).
// Ports
//   clk, rst_n (sync, active-low), stall_e (hold), flush_e (bubble)
//   *_d          decode-stage instruction fields and control strobes
//   *_m, *_w     MEM / WB forwarding sources and destinations
//   src_a_e, src_b_e, alu_ctrl_e   ALU operands and operation
//   write_data_e forwarded rs2 for stores;  pc_target_e = pc_e + imm_ext_e
//   pc_e, pcplus4_e, rs1_e, rs2_e, rd_e, control strobes, result_src_e, valid_e
//   fwd_a_sel_e, fwd_b_sel_e  forwarding choice, for the hazard unit / debug
// Configuration
//   IDEX_FWD_EN defined   : MEM/WB forwarding enabled.
//   IDEX_FWD_EN undefined : operands come straight from rd1_e/rd2_e, selects stay
//                           FWD_NONE; M/W ports remain but are ignored.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CONTROL_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_e,
  input  logic                      flush_e,
  input  logic                      valid_d,
  input  logic [DATA_WIDTH-1:0]     rd1_d,
  input  logic [DATA_WIDTH-1:0]     rd2_d,
  input  logic [DATA_WIDTH-1:0]     pc_d,
  input  logic [DATA_WIDTH-1:0]     pcplus4_d,
  input  logic [DATA_WIDTH-1:0]     imm_ext_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic [CONTROL_WIDTH-1:0]  alu_ctrl_d,
  input  logic                      alu_src_a_d,
  input  logic                      alu_src_b_d,
  input  logic                      reg_write_d,
  input  logic                      mem_write_d,
  input  logic                      branch_d,
  input  logic                      jump_d,
  input  logic [1:0]                result_src_d,
  input  logic [DATA_WIDTH-1:0]     alu_result_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [DATA_WIDTH-1:0]     result_w,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  output logic [DATA_WIDTH-1:0]     src_a_e,
  output logic [DATA_WIDTH-1:0]     src_b_e,
  output logic [CONTROL_WIDTH-1:0]  alu_ctrl_e,
  output logic [DATA_WIDTH-1:0]     write_data_e,
  output logic [DATA_WIDTH-1:0]     pc_target_e,
  output logic [DATA_WIDTH-1:0]     pc_e,
  output logic [DATA_WIDTH-1:0]     pcplus4_e,
  output logic [REG_ADDR_WIDTH-1:0] rs1_e,
  output logic [REG_ADDR_WIDTH-1:0] rs2_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,
  output logic                      reg_write_e,
  output logic                      mem_write_e,
  output logic                      branch_e,
  output logic                      jump_e,
  output logic                      valid_e,
  output logic [1:0]                result_src_e,
  output fwd_sel_t                  fwd_a_sel_e,
  output fwd_sel_t                  fwd_b_sel_e
);

`ifdef IDEX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0]     rd1_p1;
  logic [DATA_WIDTH-1:0]     rd2_p1;
  logic [DATA_WIDTH-1:0]     pc_p1;
  logic [DATA_WIDTH-1:0]     pcplus4_p1;
  logic [DATA_WIDTH-1:0]     imm_ext_p1;
  logic [REG_ADDR_WIDTH-1:0] rs1_p1;
  logic [REG_ADDR_WIDTH-1:0] rs2_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic [CONTROL_WIDTH-1:0]  alu_ctrl_p1;
  logic                      alu_src_a_p1;
  logic                      alu_src_b_p1;
  logic                      reg_write_p1;
  logic                      mem_write_p1;
  logic                      branch_p1;
  logic                      jump_p1;
  logic                      vld_p1;
  logic [1:0]                result_src_p1;

  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;

  // ---- decode -> execute register boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      rd1_p1        <= '0;
      rd2_p1        <= '0;
      pc_p1         <= '0;
      pcplus4_p1    <= '0;
      imm_ext_p1    <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
      rd_p1         <= '0;
      alu_ctrl_p1   <= '0;
      alu_src_a_p1  <= 1'b0;
      alu_src_b_p1  <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      branch_p1     <= 1'b0;
      jump_p1       <= 1'b0;
      vld_p1        <= 1'b0;
      result_src_p1 <= '0;
    end else if (!stall_e) begin
      rd1_p1        <= rd1_d;
      rd2_p1        <= rd2_d;
      pc_p1         <= pc_d;
      pcplus4_p1    <= pcplus4_d;
      imm_ext_p1    <= imm_ext_d;
      rs1_p1        <= rs1_d;
      rs2_p1        <= rs2_d;
      rd_p1         <= rd_d;
      alu_ctrl_p1   <= alu_ctrl_d;
      alu_src_a_p1  <= alu_src_a_d;
      alu_src_b_p1  <= alu_src_b_d;
      reg_write_p1  <= reg_write_d;
      mem_write_p1  <= mem_write_d;
      branch_p1     <= branch_d;
      jump_p1       <= jump_d;
      vld_p1        <= valid_d;
      result_src_p1 <= result_src_d;
    end
  end

  // ---- execute: operand forwarding and selection ----
  fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .FWD_EN         (FWD_EN)
  ) u_fwd_a (
    .rs_e         (rs1_p1),
    .rf_data_e    (rd1_p1),
    .alu_result_m (alu_result_m),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .result_w     (result_w),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .fwd_data     (fwd_a),
    .fwd_sel      (fwd_a_sel_e)
  );

  fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .FWD_EN         (FWD_EN)
  ) u_fwd_b (
    .rs_e         (rs2_p1),
    .rf_data_e    (rd2_p1),
    .alu_result_m (alu_result_m),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .result_w     (result_w),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .fwd_data     (fwd_b),
    .fwd_sel      (fwd_b_sel_e)
  );

  always_comb begin
    src_a_e      = alu_src_a_p1 ? pc_p1 : fwd_a;
    src_b_e      = alu_src_b_p1 ? imm_ext_p1 : fwd_b;
    // stores need the forwarded rs2 even when SrcB is the immediate offset
    write_data_e = fwd_b;
    pc_target_e  = pc_p1 + imm_ext_p1;
  end

  assign alu_ctrl_e   = alu_ctrl_p1;
  assign pc_e         = pc_p1;
  assign pcplus4_e    = pcplus4_p1;
  assign rs1_e        = rs1_p1;
  assign rs2_e        = rs2_p1;
  assign rd_e         = rd_p1;
  assign reg_write_e  = reg_write_p1;
  assign mem_write_e  = mem_write_p1;
  assign branch_e     = branch_p1;
  assign jump_e       = jump_p1;
  assign valid_e      = vld_p1;
  assign result_src_e = result_src_p1;

endmodule
